// File: rtl/fifo_stream_drain_if.sv
// Stream-side handshake bundle for fifo_stream_drain.
//   master: drives m_data / m_valid / m_last, samples m_ready (the drain).
//   slave : samples m_data / m_valid / m_last, drives m_ready (the sink).
interface fifo_stream_drain_if #(
  parameter int unsigned FIFO_WIDTH = 16
) ();
  logic [FIFO_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;

  modport master (
    output m_data,
    output m_valid,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/fifo_stream_drain.sv
// Read-side consumer of the synchronous FIFO. Pulls words through the FIFO read port and
// re-presents them as a valid/ready stream with packet framing.
// Ports:
//   clk, rst_n        clock (rising edge) and synchronous active-low reset
//   fifo_data_out     FIFO read data, valid the cycle after fifo_rd_en is sampled
//   fifo_empty        FIFO empty flag
//   fifo_underflow    FIFO underflow flag, flags the word landing this cycle as bogus
//   fifo_rd_en        read request to the FIFO
//   enable            permits new FIFO reads
//   m                 stream interface (m_data, m_valid, m_ready, m_last)
//   beat_count        delivered-beat counter, wraps
//   underflow_err     sticky error, set when a landing word is flagged by fifo_underflow
module fifo_stream_drain #(
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned PKT_LEN    = 4,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  input  logic                  enable,
  fifo_stream_drain_if.master   m,
  output logic [CNT_WIDTH-1:0]  beat_count,
  output logic                  underflow_err
);

  localparam int unsigned    IdxW    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(PKT_LEN - 1);

  // Two-entry output buffer; entry 0 is the head presented on the stream.
  logic [FIFO_WIDTH-1:0] buf0_q, buf0_d;
  logic [FIFO_WIDTH-1:0] buf1_q, buf1_d;
  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [CNT_WIDTH-1:0]  beat_q, beat_d;
  logic                  uf_err_q, uf_err_d;

  logic       valid;
  logic       pop;
  logic       land;
  logic       room;
  logic [1:0] occ_pop;

  assign valid = (occ_q != 2'd0);
  assign pop   = valid && m.m_ready;
  // Word requested last cycle arrives now unless the FIFO flags it as an underflow.
  assign land  = inflight_q && !fifo_underflow;
  // Buffered + in-flight words after this cycle's pop must leave a free slot for a new read.
  assign room  = (({1'b0, occ_q} + {2'b00, inflight_q}) - {2'b00, pop}) < 3'd2;

  assign fifo_rd_en = rst_n && enable && !fifo_empty && room;

  always_comb begin
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;
    idx_d      = idx_q;
    beat_d     = beat_q;
    uf_err_d   = uf_err_q;
    inflight_d = fifo_rd_en;
    occ_pop    = occ_q - {1'b0, pop};

    if (pop) begin
      buf0_d = buf1_q;
      idx_d  = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
      beat_d = beat_q + CNT_WIDTH'(1);
    end

    // Landing word goes to the first free slot after the pop-shift.
    if (land) begin
      if (occ_pop == 2'd0) begin
        buf0_d = fifo_data_out;
      end else begin
        buf1_d = fifo_data_out;
      end
    end

    occ_d = occ_pop + {1'b0, land};

    if (inflight_q && fifo_underflow) begin
      uf_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf0_q     <= '0;
      buf1_q     <= '0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      idx_q      <= '0;
      beat_q     <= '0;
      uf_err_q   <= 1'b0;
    end else begin
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      idx_q      <= idx_d;
      beat_q     <= beat_d;
      uf_err_q   <= uf_err_d;
    end
  end

  assign m.m_valid     = valid;
  assign m.m_data      = buf0_q;
  assign m.m_last      = valid && (idx_q == IdxLast);
  assign beat_count    = beat_q;
  assign underflow_err = uf_err_q;

endmodule

// File: tb/tb_fifo_stream_drain.sv
module tb_fifo_stream_drain;
  localparam int unsigned W  = 16;
  localparam int unsigned PL = 4;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          fifo_empty;
  logic          fifo_underflow;
  logic          fifo_rd_en;
  logic [W-1:0]  fifo_data_out;
  logic [CW-1:0] beat_count;
  logic          underflow_err;

  fifo_stream_drain_if #(.FIFO_WIDTH(W)) s ();

  fifo_stream_drain #(
    .FIFO_WIDTH (W),
    .PKT_LEN    (PL),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fifo_data_out  (fifo_data_out),
    .fifo_empty     (fifo_empty),
    .fifo_underflow (fifo_underflow),
    .fifo_rd_en     (fifo_rd_en),
    .enable         (enable),
    .m              (s),
    .beat_count     (beat_count),
    .underflow_err  (underflow_err)
  );

  always #5 clk = ~clk;

  // Reference model: FIFO contents, words owed to the stream in order, and the word in flight.
  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_q[$];
  bit           infl;
  bit           infl_uf;
  logic [W-1:0] infl_w;
  int           cnt;
  int           pidx;
  bit           uf_err;
  int           uf_countdown;
  int           rd_total;
  int           last_pops;
  int           pops_total;
  int           errors;
  int           checks;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] w);
    fifo_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // One clock: check outputs mid-low-phase, then advance the model on the edge.
  task automatic cycle();
    bit           exp_valid;
    bit           pop;
    bit           exp_rd;
    bit           rd;
    logic [W-1:0] w;
    #1;
    exp_valid = exp_q.size() != 0;
    pop       = exp_valid && s.m_ready;
    chk("m_valid", 32'(s.m_valid), 32'(exp_valid));
    if (exp_valid) begin
      chk("m_data", 32'(s.m_data), 32'(exp_q[0]));
      chk("m_last", 32'(s.m_last), 32'(pidx == PL - 1));
    end else begin
      chk("m_last_idle", 32'(s.m_last), 32'(0));
    end
    chk("beat_count", 32'(beat_count), 32'(cnt[CW-1:0]));
    chk("underflow_err", 32'(underflow_err), 32'(uf_err));
    exp_rd = rst_n && enable && (fifo_q.size() != 0) &&
             ((exp_q.size() + int'(infl) - int'(pop)) < 2);
    chk("fifo_rd_en", 32'(fifo_rd_en), 32'(exp_rd));
    rd = fifo_rd_en;
    // m_valid must not follow m_ready combinationally.
    s.m_ready = ~s.m_ready;
    #1;
    chk("valid_vs_ready", 32'(s.m_valid), 32'(exp_valid));
    s.m_ready = ~s.m_ready;
    #1;
    if (rd) rd_total++;
    if (pop && rst_n) begin
      pops_total++;
      if (pidx == PL - 1) last_pops++;
    end
    @(posedge clk);
    #1;
    if (!rst_n) begin
      exp_q.delete();
      cnt    = 0;
      pidx   = 0;
      uf_err = 1'b0;
    end else begin
      if (pop) begin
        void'(exp_q.pop_front());
        cnt++;
        pidx = (pidx + 1) % PL;
      end
      if (infl) begin
        if (infl_uf) uf_err = 1'b1;
        else exp_q.push_back(infl_w);
      end
    end
    infl = rd;
    if (rd) begin
      if (fifo_q.size() == 0) begin
        w              = W'($urandom);
        fifo_underflow = 1'b1;
      end else begin
        w = fifo_q.pop_front();
        if (uf_countdown > 0) begin
          uf_countdown--;
          fifo_underflow = (uf_countdown == 0);
        end else begin
          fifo_underflow = 1'b0;
        end
      end
      fifo_data_out = w;
      infl_w        = w;
      infl_uf       = fifo_underflow;
    end else begin
      fifo_underflow = 1'b0;
      fifo_data_out  = W'($urandom);
    end
    fifo_empty = (fifo_q.size() == 0);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int start;
    errors = 0; checks = 0; cnt = 0; pidx = 0; uf_err = 0; infl = 0; infl_uf = 0;
    infl_w = '0; uf_countdown = 0; rd_total = 0; last_pops = 0; pops_total = 0;
    rst_n = 1'b0; enable = 1'b0; s.m_ready = 1'b0;
    fifo_empty = 1'b1; fifo_underflow = 1'b0; fifo_data_out = '0;
    @(posedge clk);
    @(negedge clk);
    run(2);

    // Preloaded burst, sink always ready.
    push(16'h0A01); push(16'h0A02); push(16'h0A03);
    cycle();
    rst_n = 1'b1; enable = 1'b1; s.m_ready = 1'b1;
    run(7);
    chk("t1_count", 32'(beat_count), 32'(3));
    chk("t1_uf", 32'(underflow_err), 32'(0));

    // Sink stalled: only two reads may be outstanding.
    s.m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(16'h0B00 + 16'(i));
    start = rd_total;
    run(6);
    chk("t2_rd_pulses", 32'(rd_total - start), 32'(2));
    s.m_ready = 1'b1;
    run(9);
    chk("t2_count", 32'(beat_count), 32'(8));

    // Alternating ready: m_last on beats 4 and 8 of the packet pair.
    for (int i = 0; i < 8; i++) push(16'h0C00 + 16'(i));
    start = last_pops;
    for (int i = 0; i < 24; i++) begin
      s.m_ready = (i % 2 == 0);
      cycle();
    end
    chk("t3_lasts", 32'(last_pops - start), 32'(2));
    s.m_ready = 1'b1;
    run(3);

    // Drop enable right after the second read of a 6-word burst.
    for (int i = 0; i < 6; i++) push(16'h0D00 + 16'(i));
    start = rd_total;
    for (int i = 0; i < 20 && (rd_total - start) < 2; i++) cycle();
    chk("t4_two_reads", 32'(rd_total - start), 32'(2));
    enable = 1'b0;
    run(6);
    chk("t4_no_reads", 32'(rd_total - start), 32'(2));
    enable = 1'b1;
    run(10);
    chk("t4_reads", 32'(rd_total - start), 32'(6));

    // Underflow on the landing of the 2nd of 3 reads.
    start = pops_total;
    uf_countdown = 2;
    push(16'h0E01); push(16'h0E02); push(16'h0E03);
    run(8);
    chk("t5_uf", 32'(underflow_err), 32'(1));
    chk("t5_delivered", 32'(pops_total - start), 32'(2));
    run(3);

    // Reset with a word buffered and one in flight.
    s.m_ready = 1'b0;
    push(16'h0F01); push(16'h0F02); push(16'h0F03);
    for (int i = 0; i < 10 && !(exp_q.size() == 1 && infl); i++) cycle();
    chk("t6_reach", 32'(exp_q.size() == 1 && infl), 32'(1));
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();
    chk("t6_uf_cleared", 32'(underflow_err), 32'(0));
    s.m_ready = 1'b1;
    run(6);

    // Randomized traffic with occasional underflow and reset.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) push(W'($urandom));
      enable    = ($urandom_range(0, 7) != 0);
      s.m_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 50) == 0) uf_countdown = 1;
      rst_n = ($urandom_range(0, 200) != 0);
      cycle();
    end
    rst_n = 1'b1; enable = 1'b1; s.m_ready = 1'b1;
    for (int i = 0; i < 400 && (fifo_q.size() != 0 || exp_q.size() != 0 || infl); i++) cycle();
    chk("drained", 32'(fifo_q.size() + exp_q.size() + int'(infl)), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
